// File: rtl/double_threshold_hysteresis.sv
// rtl/double_threshold_hysteresis.sv - two-threshold hysteresis edge linker over a streamed 3x3 class window
// Optional macro DTH_EIGHT_CONN_EN: link through all 8 neighbours (default: 4 orthogonal neighbours).
module double_threshold_hysteresis #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [10:0] in_mag,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic        [10:0] thr_low,
    input  logic        [10:0] thr_high,
    output logic               out_edge,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_done
);
    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int HIST = 2 * IMG_WIDTH + 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_WEAK   = 2'd1;
    localparam logic [1:0] CLS_STRONG = 2'd2;

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t        state_q;
    logic [CW-1:0] in_col_q, out_col_q;
    logic [RW-1:0] in_row_q, out_row_q;
    logic [10:0]   thr_lo_q, thr_hi_q;
    logic          out_valid_q, out_edge_q, out_last_q;
    // Two image lines plus two classes of raster history; the 3x3 window is a set of fixed taps.
    logic [1:0]    hist_q [HIST];

    logic          slot_free, accept, first_px, gen, shift;
    logic          up_ok, dn_ok, lf_ok, rt_ok, strong_nb, edge_d, out_last_d;
    logic [10:0]   mag_u, thr_lo_eff, thr_hi_eff;
    logic [1:0]    in_cls, new_cls, centre;

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state_q == S_FILL)
                in_ready = 1'b1;
            else if (state_q == S_RUN)
                in_ready = slot_free;
        end
    end

    assign accept   = in_valid && in_ready;
    assign first_px = (state_q == S_FILL) && (in_row_q == '0) && (in_col_q == '0);

    // The first pixel of a frame is classified with the thresholds being captured that cycle.
    always_comb begin
        thr_hi_eff = thr_hi_q;
        thr_lo_eff = thr_lo_q;
        if (first_px) begin
            thr_hi_eff = thr_high;
            thr_lo_eff = (thr_low > thr_high) ? thr_high : thr_low;
        end
    end

    always_comb begin
        mag_u  = in_mag[10] ? 11'd0 : $unsigned(in_mag);
        in_cls = CLS_NONE;
        if (mag_u >= thr_hi_eff)
            in_cls = CLS_STRONG;
        else if (mag_u >= thr_lo_eff)
            in_cls = CLS_WEAK;
    end

    assign gen     = ((state_q == S_RUN) && accept) || ((state_q == S_FLUSH) && slot_free);
    assign shift   = accept || ((state_q == S_FLUSH) && slot_free);
    assign new_cls = (state_q == S_FLUSH) ? CLS_NONE : in_cls;
    assign centre  = hist_q[IMG_WIDTH];

    always_comb begin
        up_ok     = (out_row_q != '0);
        dn_ok     = (out_row_q != ROW_LAST);
        lf_ok     = (out_col_q != '0);
        rt_ok     = (out_col_q != COL_LAST);
        strong_nb = (up_ok && hist_q[2*IMG_WIDTH]   == CLS_STRONG)
                 || (dn_ok && hist_q[0]             == CLS_STRONG)
                 || (lf_ok && hist_q[IMG_WIDTH + 1] == CLS_STRONG)
                 || (rt_ok && hist_q[IMG_WIDTH - 1] == CLS_STRONG);
`ifdef DTH_EIGHT_CONN_EN
        strong_nb = strong_nb
                 || (up_ok && lf_ok && hist_q[2*IMG_WIDTH + 1] == CLS_STRONG)
                 || (up_ok && rt_ok && hist_q[2*IMG_WIDTH - 1] == CLS_STRONG)
                 || (dn_ok && lf_ok && hist_q[1]               == CLS_STRONG)
                 || (dn_ok && rt_ok && new_cls                 == CLS_STRONG);
`endif
        edge_d     = (centre == CLS_STRONG) || ((centre == CLS_WEAK) && strong_nb);
        out_last_d = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            hist_q[0] <= new_cls;
            for (int i = 1; i < HIST; i++)
                hist_q[i] <= hist_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            thr_lo_q    <= '0;
            thr_hi_q    <= '0;
            out_valid_q <= 1'b0;
            out_edge_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (first_px) begin
                    thr_lo_q <= thr_lo_eff;
                    thr_hi_q <= thr_hi_eff;
                end
                if (in_col_q == COL_LAST) begin
                    in_col_q <= '0;
                    in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
                end else begin
                    in_col_q <= in_col_q + 1'b1;
                end
            end

            case (state_q)
                S_FILL:  if (accept && in_row_q == RW'(1) && in_col_q == '0)
                             state_q <= S_RUN;
                S_RUN:   if (accept && in_row_q == ROW_LAST && in_col_q == COL_LAST)
                             state_q <= S_FLUSH;
                S_FLUSH: if (gen && out_last_d)
                             state_q <= S_FILL;
                default: state_q <= S_FILL;
            endcase

            if (gen) begin
                out_valid_q <= 1'b1;
                out_edge_q  <= edge_d;
                out_last_q  <= out_last_d;
                if (out_col_q == COL_LAST) begin
                    out_col_q <= '0;
                    out_row_q <= out_last_d ? '0 : out_row_q + 1'b1;
                end else begin
                    out_col_q <= out_col_q + 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_edge   = out_edge_q;
    assign frame_done = out_valid_q && out_ready && out_last_q;

endmodule

// File: tb/tb_double_threshold_hysteresis.sv
// tb/tb_double_threshold_hysteresis.sv - randomized self-checking bench against a 2-D hysteresis model
module tb_double_threshold_hysteresis;
    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [10:0] in_mag;
    logic               in_valid, in_ready;
    logic        [10:0] thr_low, thr_high;
    logic               out_edge, out_valid, out_ready, frame_done;

    double_threshold_hysteresis #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .in_mag(in_mag), .in_valid(in_valid), .in_ready(in_ready),
        .thr_low(thr_low), .thr_high(thr_high), .out_edge(out_edge), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mag_tbl [N];
    bit exp_tbl [N];
    bit got_q [$];
    int fd_idx, fd_cnt, flush_low, lat_cyc;

    task automatic fill_all(input int v);
        for (int i = 0; i < N; i++) mag_tbl[i] = v;
    endtask

    // Reference: classify every pixel, then link weak pixels to strong neighbours inside the image.
    task automatic model(input int thl, input int thh);
        int cls [H][W];
        int lo, m;
        bit e;
        lo = (thl > thh) ? thh : thl;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                m = (mag_tbl[r*W+c] < 0) ? 0 : mag_tbl[r*W+c];
                cls[r][c] = (m >= thh) ? 2 : (m >= lo) ? 1 : 0;
            end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                e = (cls[r][c] == 2);
                if (cls[r][c] == 1)
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
`ifndef DTH_EIGHT_CONN_EN
                            if (dr != 0 && dc != 0) continue;
`endif
                            if (dr == 0 && dc == 0) continue;
                            if (r+dr < 0 || r+dr >= H || c+dc < 0 || c+dc >= W) continue;
                            if (cls[r+dr][c+dc] == 2) e = 1'b1;
                        end
                exp_tbl[r*W+c] = e;
            end
    endtask

    // Streams mag_tbl as one frame with random valid/ready duty, collecting every output transfer.
    task automatic run_frame(input int thl, input int thh, input int rdy_pct, input int vld_pct);
        int sent = 0, cyc = 0, acc_cyc = -1, first_ov = -1;
        bit low_done = 1'b0;
        got_q.delete();
        fd_idx = -1; fd_cnt = 0; flush_low = 0; lat_cyc = -1;
        thr_low = 11'(thl); thr_high = 11'(thh);
        while (got_q.size() < N && cyc < 3000) begin
            @(negedge clk);
            if (sent >= 1) begin
                thr_low  = 11'($urandom);
                thr_high = 11'($urandom);
            end
            in_valid  = (sent < N) && ($urandom_range(99) < vld_pct);
            in_mag    = (sent < N) ? 11'(mag_tbl[sent]) : 11'(0);
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (sent == N && !low_done) begin
                if (in_ready) low_done = 1'b1;
                else flush_low++;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) got_q.push_back(out_edge);
            if (frame_done) begin
                fd_cnt++;
                fd_idx = got_q.size();
            end
            if (in_valid && in_ready) begin
                if (sent == W + 1) acc_cyc = cyc;
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (acc_cyc >= 0 && first_ov >= 0) lat_cyc = first_ov - acc_cyc;
        n_cmp++;
        if (got_q.size() != N)
            $display("FAIL frame_timeout: got %0d outputs, required %0d", got_q.size(), N);
        if (got_q.size() != N) n_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_mag = '0; out_ready = 1'b1;
        thr_low = '0; thr_high = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_edge, frame_done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_state: got rdy/vld/edge/done=%b, required 0000",
                     {in_ready, out_valid, out_edge, frame_done});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_all_strong();
        fill_all(60);
        model(20, 50);
        run_frame(20, 50, 100, 100);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== 1'b1 || exp_tbl[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL all_strong[%0d]: got %0d, required 1", i, (i < got_q.size()) ? int'(got_q[i]) : -1);
            end
        end
        n_cmp++;
        if (fd_cnt !== 1 || fd_idx !== N) begin
            n_bad++;
            $display("FAIL frame_done: got %0d pulses at output %0d, required 1 at %0d", fd_cnt, fd_idx, N);
        end
        n_cmp++;
        if (flush_low !== W + 1) begin
            n_bad++;
            $display("FAIL flush_ready_low: got %0d cycles, required %0d", flush_low, W + 1);
        end
        n_cmp++;
        if (lat_cyc !== 1) begin
            n_bad++;
            $display("FAIL pixel_latency: got %0d cycles, required 1", lat_cyc);
        end
    endtask

    task automatic test_single_strong();
        int ones = 0;
        int want;
`ifdef DTH_EIGHT_CONN_EN
        want = 9;
`else
        want = 5;
`endif
        fill_all(30);
        mag_tbl[1*W+1] = 60;
        model(20, 50);
        run_frame(20, 50, 100, 100);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_tbl[i]) begin
                n_bad++;
                $display("FAIL single_strong[%0d]: got %0d, required %0d", i, (i < got_q.size()) ? int'(got_q[i]) : -1, exp_tbl[i]);
            end
            if (i < got_q.size() && got_q[i]) ones++;
        end
        n_cmp++;
        if (ones !== want) begin
            n_bad++;
            $display("FAIL single_strong_count: got %0d edges, required %0d", ones, want);
        end
    endtask

    task automatic test_row_wrap();
        int ones = 0;
        int want;
`ifdef DTH_EIGHT_CONN_EN
        want = 10;
`else
        want = 7;
`endif
        fill_all(30);
        mag_tbl[0*W+7] = 60;
        mag_tbl[1*W+0] = 60;
        model(20, 50);
        run_frame(20, 50, 100, 100);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_tbl[i]) begin
                n_bad++;
                $display("FAIL row_wrap[%0d]: got %0d, required %0d", i, (i < got_q.size()) ? int'(got_q[i]) : -1, exp_tbl[i]);
            end
            if (i < got_q.size() && got_q[i]) ones++;
        end
        n_cmp++;
        if (ones !== want) begin
            n_bad++;
            $display("FAIL row_wrap_count: got %0d edges, required %0d", ones, want);
        end
    endtask

    task automatic test_thresholds();
        fill_all(-5);
        run_frame(0, 50, 100, 100);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL negative_mag[%0d]: got %0d, required 0", i, (i < got_q.size()) ? int'(got_q[i]) : -1);
            end
        end
        fill_all(55);
        run_frame(70, 50, 100, 100);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL swapped_thr[%0d]: got %0d, required 1", i, (i < got_q.size()) ? int'(got_q[i]) : -1);
            end
        end
    endtask

    task automatic test_random_stall();
        bit ref_q [$];
        int thl, thh;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N; i++) mag_tbl[i] = int'($urandom_range(400)) - 100;
            thl = $urandom_range(200);
            thh = $urandom_range(200);
            model(thl, thh);
            run_frame(thl, thh, 100, 100);
            ref_q = got_q;
            run_frame(thl, thh, 50, 70);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (i >= got_q.size() || i >= ref_q.size() || got_q[i] !== exp_tbl[i] || ref_q[i] !== exp_tbl[i]) begin
                    n_bad++;
                    $display("FAIL random_stall it%0d[%0d]: got stalled=%0d free=%0d, required %0d", it, i,
                             (i < got_q.size()) ? int'(got_q[i]) : -1, (i < ref_q.size()) ? int'(ref_q[i]) : -1, exp_tbl[i]);
                end
            end
            n_cmp++;
            if (fd_cnt !== 1 || fd_idx !== N) begin
                n_bad++;
                $display("FAIL random_stall_done it%0d: got %0d pulses at %0d, required 1 at %0d", it, fd_cnt, fd_idx, N);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int sent = 0, cyc = 0;
        fill_all(60);
        thr_low = 11'd20; thr_high = 11'd50; out_ready = 1'b1;
        while (sent < 13 && cyc < 100) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mag   = 11'sd60;
            #1;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_state: got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        fill_all(30);
        mag_tbl[1*W+1] = 60;
        model(20, 50);
        run_frame(20, 50, 100, 100);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_tbl[i]) begin
                n_bad++;
                $display("FAIL mid_reset[%0d]: got %0d, required %0d", i, (i < got_q.size()) ? int'(got_q[i]) : -1, exp_tbl[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_strong();
        test_single_strong();
        test_row_wrap();
        test_thresholds();
        test_random_stall();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
